// File: rtl/icache_direct_mapped_if.sv
// Bundle of the fetch-side and memory-side signals of the direct-mapped
// instruction cache. The cache uses the slave view. The fetch stage and the
// memory controller, or a bench standing in for them, use the master view.
interface icache_direct_mapped_if;
    // fetch stage side
    logic         fetch_en;
    logic [31:0]  fetch_pc;
    logic         flush;
    logic         instr_valid;
    logic [31:0]  instr;
    // memory controller side
    logic         mem_query_en;
    logic [31:0]  mem_head_addr;
    logic         mem_block_en;
    logic [127:0] mem_block_data;

    modport slave (
        input  fetch_en, fetch_pc, flush, mem_block_en, mem_block_data,
        output instr_valid, instr, mem_query_en, mem_head_addr
    );

    modport master (
        output fetch_en, fetch_pc, flush, mem_block_en, mem_block_data,
        input  instr_valid, instr, mem_query_en, mem_head_addr
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache. A hit answers one cycle after the fetch.
// A miss requests one aligned 4-word block from memory, installs it, and
// forwards the requested word straight from the fill data. Any response
// that is pending when a flush arrives is dropped.
module icache_direct_mapped #(
    parameter int INDEX_WIDTH = 4,
    parameter int BLOCK_WIDTH = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    icache_direct_mapped_if.slave   bus
);
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 32 - 4 - INDEX_WIDTH;
    localparam int BLK_WIDTH = 28;   // pc[31:4]: block number

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // Selects the 32-bit word at a given word offset inside a 128-bit block.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] off);
        logic [31:0] w;
        case (off)
            2'd0:    w = blk[31:0];
            2'd1:    w = blk[63:32];
            2'd2:    w = blk[95:64];
            2'd3:    w = blk[127:96];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // line storage
    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [127:0]         data_q [LINES];

    // control registers
    state_t               state_q,       state_d;
    logic [BLK_WIDTH-1:0] blk_q,         blk_d;     // latched miss block number
    logic [1:0]           off_q,         off_d;     // latched miss word offset
    logic                 drop_q,        drop_d;    // response must be discarded
    logic                 instr_valid_q, instr_valid_d;
    logic [31:0]          instr_q,       instr_d;

    logic                   line_we_s;
    logic [INDEX_WIDTH-1:0] fetch_idx_s;
    logic [TAG_WIDTH-1:0]   fetch_tag_s;
    logic [INDEX_WIDTH-1:0] fill_idx_s;
    logic [TAG_WIDTH-1:0]   fill_tag_s;
    logic                   hit_s;
    logic [31:0]            hit_word_s;
    logic [1:0]             unused_pc_s;

    // The byte offset within a word never matters to an instruction fetch.
    assign unused_pc_s = bus.fetch_pc[1:0];

    assign fetch_idx_s = bus.fetch_pc[3+INDEX_WIDTH:4];
    assign fetch_tag_s = bus.fetch_pc[31:4+INDEX_WIDTH];
    assign fill_idx_s  = blk_q[INDEX_WIDTH-1:0];
    assign fill_tag_s  = blk_q[BLK_WIDTH-1:INDEX_WIDTH];
    assign hit_s       = valid_q[fetch_idx_s] && (tag_q[fetch_idx_s] == fetch_tag_s);
    assign hit_word_s  = word_sel(data_q[fetch_idx_s], bus.fetch_pc[3:2]);

    // The request drops in the same cycle the block arrives, so the memory
    // controller never sees a second request for the same block. It comes
    // straight from state, so a reset withdraws it at once.
    assign bus.mem_query_en  = (state_q == ST_FILL) && !bus.mem_block_en;
    assign bus.mem_head_addr = {blk_q, 4'b0000};
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr         = instr_q;

    // Next-state and response logic. When rdy_in is low, nothing changes.
    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        off_d         = off_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        line_we_s     = 1'b0;
        if (rdy_in) begin
            instr_valid_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.flush) begin
                        // a flush wins over a fetch in the same cycle; no lookup
                        state_d = ST_IDLE;
                    end else if (bus.fetch_en) begin
                        if (hit_s) begin
                            instr_valid_d = 1'b1;
                            instr_d       = hit_word_s;
                        end else begin
                            blk_d   = bus.fetch_pc[31:4];
                            off_d   = bus.fetch_pc[3:2];
                            drop_d  = 1'b0;
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    // the memory controller cannot cancel, so a flush only
                    // marks the response for dropping
                    if (bus.flush) begin
                        drop_d = 1'b1;
                    end else begin
                        drop_d = drop_q;
                    end
                    if (bus.mem_block_en) begin
                        line_we_s = 1'b1;
                        state_d   = ST_IDLE;
                        if (!drop_q && !bus.flush) begin
                            instr_valid_d = 1'b1;
                            instr_d       = word_sel(bus.mem_block_data, off_q);
                        end else begin
                            instr_valid_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            line_we_s = 1'b0;
        end
    end

    // Control registers and line valid bits, cleared by the asynchronous reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= ST_IDLE;
            blk_q         <= '0;
            off_q         <= 2'b00;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0000_0000;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            off_q         <= off_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            if (line_we_s) begin
                valid_q[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are covered by the valid bits, so they are not reset.
    always_ff @(posedge clk_in) begin
        if (line_we_s) begin
            tag_q[fill_idx_s]  <= fill_tag_s;
            data_q[fill_idx_s] <= bus.mem_block_data;
        end
    end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped. A small memory model supplies
// fill blocks. Expected instruction words go into a scoreboard queue when a
// fetch is issued, and a monitor pops and compares them when instr_valid
// pulses.
module tb_icache_direct_mapped;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    icache_direct_mapped_if bus ();

    icache_direct_mapped #(.INDEX_WIDTH(4), .BLOCK_WIDTH(2)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: word k of the block at address a is a ^ (0x11 * k).
    function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
        logic [31:0] base;
        base = {a[31:4], 4'b0000};
        return base ^ (32'h0000_0011 * 32'(k));
    endfunction

    function automatic logic [127:0] mem_block(input logic [31:0] a);
        logic [127:0] b;
        for (int k = 0; k < 4; k++) begin
            b[32*k +: 32] = mem_word(a, k);
        end
        return b;
    endfunction

    // Monitor: every instr_valid pulse must match the oldest expected word.
    always @(negedge clk_in) begin
        if (bus.instr_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("resp_expected", 32'(sb.size()), 32'd1);
            end else begin
                check("instr", bus.instr, sb.pop_front());
            end
        end
    end

    // Drive one fetch for one cycle. Afterwards the hit response or the miss
    // request is visible.
    task automatic fetch(input logic [31:0] pc);
        bus.fetch_en = 1'b1;
        bus.fetch_pc = pc;
        @(negedge clk_in);
        bus.fetch_en = 1'b0;
    endtask

    task automatic fetch_hit(input string tag, input logic [31:0] pc);
        sb.push_back(mem_word(pc, int'(pc[3:2])));
        fetch(pc);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_noquery"}, 32'(bus.mem_query_en), 32'd0);
    endtask

    task automatic fetch_miss(input string tag, input logic [31:0] pc);
        fetch(pc);
        check({tag, "_query"}, 32'(bus.mem_query_en), 32'd1);
        check({tag, "_head"}, bus.mem_head_addr, {pc[31:4], 4'b0000});
        check({tag, "_novalid"}, 32'(bus.instr_valid), 32'd0);
    endtask

    // Return the block for pc. Expect the word only when deliver is set.
    task automatic fill(input string tag, input logic [31:0] pc, input bit deliver);
        bus.mem_block_en   = 1'b1;
        bus.mem_block_data = mem_block(pc);
        #1;
        check({tag, "_query_drop"}, 32'(bus.mem_query_en), 32'd0);
        if (deliver) sb.push_back(mem_word(pc, int'(pc[3:2])));
        @(negedge clk_in);
        bus.mem_block_en = 1'b0;
        #1;
        check({tag, "_valid"}, 32'(bus.instr_valid), deliver ? 32'd1 : 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_idle"}, 32'(bus.mem_query_en), 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.fetch_en       = 1'b0;
        bus.fetch_pc       = 32'h0000_0000;
        bus.flush          = 1'b0;
        bus.mem_block_en   = 1'b0;
        bus.mem_block_data = 128'h0;
        repeat (2) @(negedge clk_in);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'h0000_0000);
        check("rst_query", 32'(bus.mem_query_en), 32'd0);
        check("rst_head", bus.mem_head_addr, 32'h0000_0000);
        rst_in = 1'b1;
        @(negedge clk_in);

        // cold miss, then hit in the same line
        fetch_miss("miss0", 32'h0000_0000);
        fill("fill0", 32'h0000_0000, 1'b1);
        fetch_hit("hit8", 32'h0000_0008);

        // same index, different tag: evict, then the old block misses again
        fetch_miss("miss100", 32'h0000_0100);
        fill("fill100", 32'h0000_0100, 1'b1);
        fetch_miss("miss0b", 32'h0000_0000);
        fill("fill0b", 32'h0000_0000, 1'b1);

        // flush during a fill drops the response, but the line is installed
        fetch_miss("miss44", 32'h0000_0044);
        bus.flush = 1'b1;
        @(negedge clk_in);
        bus.flush = 1'b0;
        check("flushfill_query", 32'(bus.mem_query_en), 32'd1);
        fill("fill44", 32'h0000_0044, 1'b0);
        fetch_hit("hit44", 32'h0000_0044);

        // flush together with a fetch that would hit: no lookup at all
        bus.flush    = 1'b1;
        bus.fetch_en = 1'b1;
        bus.fetch_pc = 32'h0000_0000;
        @(negedge clk_in);
        bus.flush    = 1'b0;
        bus.fetch_en = 1'b0;
        check("flushidle_valid", 32'(bus.instr_valid), 32'd0);
        check("flushidle_query", 32'(bus.mem_query_en), 32'd0);

        // rdy_in low during a fill freezes everything
        fetch_miss("miss208", 32'h0000_0208);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("stall_query", 32'(bus.mem_query_en), 32'd1);
            check("stall_head", bus.mem_head_addr, 32'h0000_0200);
            check("stall_valid", 32'(bus.instr_valid), 32'd0);
        end
        rdy_in = 1'b1;
        fill("fill208", 32'h0000_0208, 1'b1);

        // reset during a fill: the request drops at once, and a late block is ignored
        fetch_miss("miss300", 32'h0000_0300);
        rst_in = 1'b0;
        #1;
        check("rstfill_query", 32'(bus.mem_query_en), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        bus.mem_block_en   = 1'b1;
        bus.mem_block_data = mem_block(32'h0000_0300);
        @(negedge clk_in);
        bus.mem_block_en = 1'b0;
        #1;
        check("stray_valid", 32'(bus.instr_valid), 32'd0);
        check("stray_query", 32'(bus.mem_query_en), 32'd0);
        fetch_miss("missrst", 32'h0000_0000);
        fill("fillrst", 32'h0000_0000, 1'b1);

        @(negedge clk_in);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped instruction cache between the instruction-fetch stage and the memory controller's ICache port.
- Serves 32-bit instruction words to fetch.
- On a miss, requests one aligned 16-byte block (4 words) from the memory controller and installs it.
- Returns the requested word directly from the fill data.

Parameters:
INDEX_WIDTH, 4, log2 of line count (default 16 lines).
BLOCK_WIDTH, 2, log2 of words per block. Fixed at 2 to match the memory controller's 128-bit block; must not be changed.

Ports:
clk_in  in  1  clock; all state changes on posedge.
rst_in  in  1  reset, asynchronous, active-low.
rdy_in  in  1  global ready; when low, all state holds.
fetch_en  in  1  fetch request; sampled only in IDLE.
fetch_pc  in  32  byte address of instruction; bits [1:0] ignored.
flush  in  1  pipeline flush (mispredict); drops any pending response.
instr_valid  out  1  one-cycle pulse: instr holds the requested word.
instr  out  32  instruction word.
mem_query_en  out  1  block request to memory controller.
mem_head_addr  out  32  block-aligned address, {pc[31:4], 4'b0}.
mem_block_en  in  1  one-cycle pulse: block data valid.
mem_block_data  in  128  block; word k occupies bits [32k+31:32k], byte 0 in LSBs.

Behaviour:
- Address split:
  - word offset = pc[3:2]
  - index = pc[3+INDEX_WIDTH:4]
  - tag = pc[31:4+INDEX_WIDTH]
- Storage: per line, a valid bit, a tag, and 128 data bits.
- Reset (rst_in low, asynchronous):
  - all valid bits cleared; state = IDLE
  - instr_valid = 0, instr = 0, mem_head_addr = 0
  - pending-drop flag cleared
  - mem_query_en = 0 (state-derived)
  - tag and data arrays need not be reset.
- rdy_in low: no register updates. mem_query_en still reflects current state.
- States: IDLE, FILL.
- instr_valid defaults to 0 every active cycle unless set as below.
- IDLE:
  - flush high: no lookup. Flush has priority over a simultaneous fetch_en.
  - fetch_en high and hit (valid && tag match): next edge sets instr_valid = 1 and instr = the selected word; stay IDLE. Hit latency is 1 cycle.
  - fetch_en high and miss: latch pc; mem_head_addr <= {fetch_pc[31:4], 4'b0}; drop flag <= 0; go to FILL.
- FILL:
  - mem_query_en = (state == FILL) && !mem_block_en, combinationally. It therefore drops in the same cycle block_en arrives, so the controller never re-issues the request.
  - fetch_en is ignored; fetch must keep waiting until instr_valid.
  - flush in FILL: drop flag <= 1. The fill is not aborted, because the controller has no cancel.
  - On mem_block_en:
    - write the line (valid = 1, tag and data from the latched pc)
    - go to IDLE
    - if drop flag == 0 and flush is low this cycle: instr_valid <= 1 and instr <= word[latched pc[3:2]] taken directly from mem_block_data.
  - Miss latency: response is the cycle after mem_block_en.
- mem_block_en in IDLE (e.g. after reset mid-fill) is ignored; no array write.
- Reset mid-fill: the request is abandoned and mem_query_en drops immediately. The cache relies on the controller completing and its late pulse being ignored.
- Aliasing: a fill always replaces the line at its index, regardless of prior contents.
- Single outstanding miss; no prefetch; no write port; no self-modifying-code coherence.

Test Plan:
- Reset, then fetch pc=0x0000: miss → mem_query_en=1, mem_head_addr=0x0. Reply block_en with data words {W3..W0}={0x33,0x22,0x11,0x00} → next cycle instr_valid=1, instr=0x00; query_en=0 in the block_en cycle.
- Then fetch pc=0x0008 → hit, instr_valid=1 one cycle later, instr=0x22, no memory request.
- Fetch pc=0x0100 (same index 0, different tag) → miss and refill. Then pc=0x0000 → miss again (eviction verified).
- Miss on pc=0x0044, assert flush while in FILL, then block_en → instr_valid stays 0. A following fetch of pc=0x0044 hits (line was installed).
- Simultaneous flush and fetch_en in IDLE → no lookup, no request, instr_valid=0. Hold rdy_in=0 for 3 cycles during FILL with block_en low → state and outputs unchanged.
- Pull rst_in low mid-FILL → mem_query_en drops asynchronously. A subsequent stray block_en does not set instr_valid, and fetch pc=0x0000 misses (valids cleared).
